// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 32-bit ALU between NUM_REQ
// valid/ready requesters, with a single tagged response register.
// Optional build macro: ALU_ARB_STATS_EN adds per-requester saturating
// 16-bit grant counters on output grant_count.

// Shared 32-bit ALU: one-hot enables; no enable asserted returns 0.
module alu (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_add_en,
  input  logic        i_sub_en,
  input  logic        i_xor_en,
  input  logic        i_or_en,
  input  logic        i_and_en,
  output logic [31:0] o_result
);
  // OR of gated results; with one-hot enables only one term is non-zero
  always_comb begin
    o_result = 32'd0;
    if (i_add_en) o_result = o_result | (i_a + i_b);
    if (i_sub_en) o_result = o_result | (i_a - i_b);
    if (i_xor_en) o_result = o_result | (i_a ^ i_b);
    if (i_or_en)  o_result = o_result | (i_a | i_b);
    if (i_and_en) o_result = o_result | (i_a & i_b);
  end
endmodule

module alu_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [3*NUM_REQ-1:0]   req_op,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_data
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]  grant_count
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_last_grant;
  logic [ID_W-1:0] r_rsp_id;
  logic [31:0]     r_rsp_data;

  logic            w_found;
  logic [ID_W-1:0] w_grant;
  logic            w_can_accept;
  logic            w_accept;
  logic [2:0]      w_op;
  logic [31:0]     w_a;
  logic [31:0]     w_b;
  logic [31:0]     w_alu_result;

  assign w_can_accept = (r_state == EMPTY) || rsp_ready;
  assign w_accept     = w_found && w_can_accept;

  // Round-robin search starting one past the last accepted requester
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_v;
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(r_last_grant) + i) % NUM_REQ;
      idx_v = idx[ID_W-1:0];
      if (!w_found && req_valid[idx_v]) begin
        w_found = 1'b1;
        w_grant = idx_v;
      end
    end
  end

  // Ready only to the winner, and only when the result slot can take it
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_grant] = 1'b1;
  end

  assign w_op = req_op[int'(w_grant)*3 +: 3];
  assign w_a  = req_a[int'(w_grant)*32 +: 32];
  assign w_b  = req_b[int'(w_grant)*32 +: 32];

  // Enables fire only on acceptance; illegal ops (5-7) leave all low
  alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_add_en (w_accept && (w_op == 3'd0)),
    .i_sub_en (w_accept && (w_op == 3'd1)),
    .i_xor_en (w_accept && (w_op == 3'd2)),
    .i_or_en  (w_accept && (w_op == 3'd3)),
    .i_and_en (w_accept && (w_op == 3'd4)),
    .o_result (w_alu_result)
  );

  // EMPTY/FULL result register; accept overwrites, bare handshake drains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= EMPTY;
      r_rsp_id     <= '0;
      r_rsp_data   <= 32'd0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_state      <= FULL;
      r_rsp_id     <= w_grant;
      r_rsp_data   <= w_alu_result;
      r_last_grant <= w_grant;
    end else if ((r_state == FULL) && rsp_ready) begin
      r_state      <= EMPTY;
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

`ifdef ALU_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [15:0] r_count;
      // Count accepts for this requester, sticking at the maximum
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_count <= 16'd0;
        end else if (w_accept && (w_grant == ID_W'(gi)) && (r_count != 16'hFFFF)) begin
          r_count <= r_count + 16'd1;
        end
      end
      assign grant_count[gi*16 +: 16] = r_count;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a response scoreboard; expected
// results are pushed on acceptance and popped by an independent monitor.
module tb_alu_arbiter;
  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [3*N-1:0]  req_op = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [0:0]      rsp_id;
  logic [31:0]     rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [16*N-1:0] grant_count;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  typedef struct packed {
    logic [0:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   quiet  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void push(input int id, input logic [31:0] data);
    exp_t e;
    e.id   = 1'(id);
    e.data = data;
    sb.push_back(e);
  endfunction

  task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[r*3 +: 3]  = op;
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_valid[r]      = 1'b1;
  endtask

  // Present a request, wait (bounded) for its handshake, then withdraw it
  task automatic issue(input int r, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    bit got = 1'b0;
    set_req(r, op, a, b);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        push(r, exp);
        got = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    check("accept_in_time", 32'(got), 32'd1);
  endtask

  // Monitor: every response handshake is compared against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual id=%0d data=%h required=none", rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", rsp_data, e.data);
        if (!quiet) $display("RSP id=%0d data=%h exp_id=%0d exp_data=%h", rsp_id, rsp_data, e.id, e.data);
      end
    end
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    reset = 1'b0;

    // Hold a result, then reset asynchronously mid-cycle: it is discarded
    issue(0, 3'd0, 32'd1, 32'd2, 32'd3);
    check("full_before_reset", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_data", rsp_data, 32'd0);
    check("async_rst_id", 32'(rsp_id), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;

    // Contention: requester 0 first after reset, then alternate
    rsp_ready = 1'b1;
    set_req(0, 3'd0, 32'd10, 32'd1);
    set_req(1, 3'd1, 32'd10, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(2'b01 << (k % 2)));
      if ((k % 2) == 0) push(0, 32'd11);
      else              push(1, 32'd9);
    end
    @(posedge clk);
    #1 req_valid = '0;

    // Single op then idle drains to EMPTY
    issue(0, 3'd0, 32'd5, 32'd7, 32'd12);
    check("single_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    check("idle_empty", 32'(rsp_valid), 32'd0);

    // Backpressure: hold FULL, requester 1 waits, outputs stable
    rsp_ready = 1'b0;
    issue(0, 3'd2, 32'h000000F0, 32'h0000000F, 32'h000000FF);
    set_req(1, 3'd3, 32'h00000100, 32'h00000001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_low", 32'(req_ready), 32'd0);
      check("bp_data_hold", rsp_data, 32'h000000FF);
      check("bp_id_hold", 32'(rsp_id), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd2);
    push(1, 32'h00000101);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    check("bp_overwrite_valid", 32'(rsp_valid), 32'd1);

    // Arithmetic edges, including an illegal op
    issue(0, 3'd1, 32'd0, 32'd1, 32'hFFFFFFFF);
    issue(1, 3'd0, 32'hFFFFFFFF, 32'd1, 32'd0);
    issue(0, 3'd2, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A);
    issue(1, 3'd7, 32'h00001234, 32'h00005678, 32'd0);
    issue(0, 3'd4, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("idle_after_ops", 32'(rsp_valid), 32'd0);

`ifdef ALU_ARB_STATS_EN
    // Counters saturate on requester 0 and stay 0 on requester 1
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("stats_rst0", 32'(grant_count[15:0]), 32'd0);
    quiet = 1'b1;
    set_req(0, 3'd0, 32'd0, 32'd0);
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      if (req_ready[0]) push(0, 32'd0);
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    check("stats_sat0", 32'(grant_count[15:0]), 32'h0000FFFF);
    check("stats_zero1", 32'(grant_count[31:16]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("stats_sb_drained", 32'(sb.size()), 32'd0);
    quiet = 1'b0;
    reset = 1'b1;
    #1;
    check("stats_clr0", 32'(grant_count[15:0]), 32'd0);
    check("stats_clr1", 32'(grant_count[31:16]), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
